// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per cycle, sign fix at the end.
// Optional macro BOOTH_DIV_EARLY_EXIT_EN: a zero divisor skips CALC and goes straight to FIX.
module booth_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           R,
  output logic                       busy,
  output logic                       done,
  output logic                       dz,
  output logic [$clog2(WIDTH+1)-1:0] n
);

  localparam int NW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem, quo, mag_b, a_cap;
  logic             sign_a, sign_b, dz_cap;

  logic [WIDTH-1:0] mag_a_in, mag_b_in, q_fix, r_fix;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    mag_a_in = A[WIDTH-1] ? -A : A;
    mag_b_in = B[WIDTH-1] ? -B : B;
    // {rem,quo} shifted left; trial is one bit wider so its MSB is the borrow
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, mag_b};
    q_fix    = (sign_a ^ sign_b) ? -quo : quo;
    r_fix    = sign_a ? -rem : rem;
    if (dz_cap) begin
      q_fix = '1;
      r_fix = a_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Q      <= '0;
      R      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      n      <= '0;
      rem    <= '0;
      quo    <= '0;
      mag_b  <= '0;
      a_cap  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz_cap <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          n    <= '0;
          if (start) begin
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
            a_cap  <= A;
            mag_b  <= mag_b_in;
            quo    <= mag_a_in;
            rem    <= '0;
            dz_cap <= (B == '0);
            busy   <= 1'b1;
`ifdef BOOTH_DIV_EARLY_EXIT_EN
            if (B == '0) begin
              state <= FIX;
            end else begin
              state <= CALC;
              n     <= NW'(WIDTH);
            end
`else
            state <= CALC;
            n     <= NW'(WIDTH);
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          n   <= n - NW'(1);
          if (n == NW'(1)) state <= FIX;
        end
        FIX: begin
          Q     <= q_fix;
          R     <= r_fix;
          dz    <= dz_cap;
          done  <= 1'b1;
          busy  <= 1'b0;
          n     <= '0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
- Sequential signed integer divider; the inverse companion of the team's sequential Booth multiplier. Same operand width and the same cycle-per-bit iterative style.
- Computes quotient and remainder of two's-complement operands using restoring division on magnitudes, with a sign-fix step at the end.
- Multi-cycle start/done handshake; sits beside the multiplier in the arithmetic datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (two's complement); legal values >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only while busy=0.
- A  input  WIDTH  dividend, signed.
- B  input  WIDTH  divisor, signed.
- Q  output  WIDTH  quotient, signed.
- R  output  WIDTH  remainder, signed.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; Q/R/dz are valid from this cycle onward.
- dz  output  1  divide-by-zero flag for the last completed operation.
- n  output  $clog2(WIDTH+1)  iterations remaining, same role as the multiplier's counter.

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-operation):
  - state goes to IDLE.
  - Q=0, R=0, busy=0, done=0, dz=0, n=0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE and DONE both accept start.
  - On start=1, A and B are captured together with their signs, |A|, |B|, and dz=(B==0).
  - Next state is CALC, with busy=1 and n=WIDTH.
- CALC (one iteration per cycle, WIDTH cycles total):
  - Shift the {rem, quo} register left by 1.
  - Trial value = rem - |B|, computed WIDTH+1 bits wide.
  - If the trial is non-negative: rem = trial and quotient LSB = 1. Otherwise keep rem and set LSB = 0.
  - n decrements by 1 each cycle. When n reaches 1, the next state is FIX.
- FIX (1 cycle):
  - Q = quo, negated if sign(A) XOR sign(B).
  - R = rem, negated if sign(A).
  - Results truncate toward zero; a nonzero R carries the sign of A.
  - Next state is DONE.
- DONE (1 cycle):
  - done=1, busy=0, n=0. Q/R/dz update here.
  - Go to IDLE, or to CALC if start=1 (back-to-back operation).
  - Q/R/dz hold their values until the next DONE or a reset.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles. Throughput is one operation per WIDTH+2 cycles.
- start is ignored while busy=1. A and B need to be stable only at the accept edge.
- Divide by zero (B==0):
  - dz=1, Q = all ones (-1), R = A.
  - Takes the full latency unless the optional feature is enabled.
- Overflow (A = -2^(WIDTH-1), B = -1):
  - Q wraps to -2^(WIDTH-1), R=0.
  - No flag is raised; this matches the multiplier's wrap semantics.
- Magnitudes are unsigned WIDTH bits, so |-2^(WIDTH-1)| is representable without an extra bit.

Optional Feature:
- Macro: BOOTH_DIV_EARLY_EXIT_EN.
- Defined: when B==0 at accept, CALC is skipped and the path is IDLE->FIX->DONE.
  - done arrives 2 cycles after the start edge.
  - n=0 throughout; dz, Q and R values are unchanged from the base behaviour.
- Undefined: B==0 runs all WIDTH CALC cycles. The datapath result is overridden in FIX to Q=-1, R=A, giving latency WIDTH+2.

Test Plan:
- WIDTH=4, A=7, B=2, start one cycle -> done exactly 6 cycles later; Q=0011, R=0001, dz=0; n counts 4,3,2,1 during CALC.
- Sign combinations -> Q=1101, R=1111 for (-7)/2; Q=1101, R=0001 for 7/(-2); Q=0011, R=1111 for (-7)/(-2).
- A=-8 (1000), B=-1 -> Q=1000, R=0000, dz=0. A=0, B=5 -> Q=0, R=0.
- A=5, B=0 -> dz=1, Q=1111, R=0101; done at 6 cycles (at 2 cycles with BOOTH_DIV_EARLY_EXIT_EN); the next valid division clears dz.
- Raise rst during the 2nd CALC cycle -> next cycle all outputs 0 and busy=0. start mid-CALC with different A/B -> ignored, and results match the original operands.
- Assert start in the DONE cycle with A=6, B=3 -> previous results still visible during DONE; new operation completes 6 cycles later with Q=0010, R=0000.
